// File: rtl/counter_sequencer_if.sv
// Handshake/status bundle between the controlling logic, the counter_sequencer
// and the downstream counter (finished flag in, enable/clear out).
interface counter_sequencer_if #(
    parameter int unsigned REPEAT_WIDTH = 8
);
    logic                    start_i;
    logic                    abort_i;
    logic                    pause_i;
    logic [REPEAT_WIDTH-1:0] repeat_count_i;
    logic                    finished_i;
    logic                    counter_enable_o;
    logic                    counter_clear_o;
    logic                    busy_o;
    logic                    done_o;
    logic [REPEAT_WIDTH-1:0] periods_done_o;

    modport master (
        output start_i, abort_i, pause_i, repeat_count_i, finished_i,
        input  counter_enable_o, counter_clear_o, busy_o, done_o, periods_done_o
    );

    modport slave (
        input  start_i, abort_i, pause_i, repeat_count_i, finished_i,
        output counter_enable_o, counter_clear_o, busy_o, done_o, periods_done_o
    );
endinterface

// File: rtl/counter_sequencer.sv
// Runs the downstream counter for N full periods with pause/abort support.
// Optional continuous mode (count 0) is enabled by COUNTER_SEQUENCER_INFINITE_EN.
module counter_sequencer #(
    parameter int unsigned REPEAT_WIDTH = 8
) (
    input  logic                clock_i,
    input  logic                reset_i,
    counter_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [REPEAT_WIDTH-1:0] target_q, target_d;
    logic [REPEAT_WIDTH-1:0] periods_q, periods_d;
    logic                    fin_prev_q, fin_prev_d;
    logic                    clear_q, clear_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    fin_edge;
    logic                    start_ok;
    logic                    run_infinite;
    logic [REPEAT_WIDTH-1:0] periods_inc;

`ifdef COUNTER_SEQUENCER_INFINITE_EN
    logic infinite_q, infinite_d;

    assign start_ok     = 1'b1;
    assign run_infinite = infinite_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            infinite_q <= 1'b0;
        end else begin
            infinite_q <= infinite_d;
        end
    end

    always_comb begin
        infinite_d = infinite_q;
        if (state_q == IDLE && bus.start_i) begin
            infinite_d = (bus.repeat_count_i == '0);
        end
    end
`else
    assign start_ok     = (bus.repeat_count_i != '0);
    assign run_infinite = 1'b0;
`endif

    assign fin_edge    = bus.finished_i & ~fin_prev_q;
    assign periods_inc = periods_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        periods_d  = periods_q;
        fin_prev_d = bus.finished_i;
        clear_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // Abort outranks everything else outside IDLE; the counter is cleared on the way out.
        if (state_q != IDLE && bus.abort_i) begin
            state_d = IDLE;
            clear_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                    if (bus.start_i && start_ok) begin
                        state_d   = CLEAR;
                        target_d  = bus.repeat_count_i;
                        periods_d = '0;
                        clear_d   = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
                CLEAR: begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
                RUN: begin
                    if (fin_edge) begin
                        periods_d = periods_inc;
                        if (!run_infinite && periods_inc == target_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = CLEAR;
                            clear_d = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            target_q   <= '0;
            periods_q  <= '0;
            fin_prev_q <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            periods_q  <= periods_d;
            fin_prev_q <= fin_prev_d;
            clear_q    <= clear_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Enable is the only combinational output so pause takes effect in the same cycle.
    assign bus.counter_enable_o = (state_q == RUN) && !bus.pause_i;
    assign bus.counter_clear_o  = clear_q;
    assign bus.busy_o           = busy_q;
    assign bus.done_o           = done_q;
    assign bus.periods_done_o   = periods_q;
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Control stage directly upstream of the `counter` block: accepts a start command with a repeat count, drives the counter's enable and clear, and counts completed counter periods by detecting rising edges of the counter's `finished` flag. It reports busy, progress and a one-cycle done pulse to the controlling logic. It lets the design run the counter for N full periods, with pause and abort, without host intervention per period.

## Interface
- `REPEAT_WIDTH`, 8: width of repeat count and progress counter.
- `clock_i` input 1: clock, all state changes on rising edge.
- `reset_i` input 1: asynchronous, active-high reset.
- `start_i` input 1: start request, sampled in IDLE only.
- `abort_i` input 1: abort request, highest priority.
- `pause_i` input 1: while high in RUN, counter enable is forced low.
- `repeat_count_i` input REPEAT_WIDTH: number of counter periods; latched on accepted start.
- `finished_i` input 1: counter's finished flag.
- `counter_enable_o` output 1: to counter `enable_i`.
- `counter_clear_o` output 1: to counter `reset_i`; one-cycle pulse.
- `busy_o` output 1: high in CLEAR and RUN.
- `done_o` output 1: one-cycle pulse on normal completion.
- `periods_done_o` output REPEAT_WIDTH: completed periods of the current or last run.

## Operation
- States: IDLE, CLEAR, RUN, DONE (state register, 2 bits).
- IDLE: `start_i`=1 and `repeat_count_i`≠0 → latch target, zero `periods_done_o`, go CLEAR. `start_i` with count 0 is ignored (see Configuration).
- CLEAR: `counter_clear_o`=1, `counter_enable_o`=0; unconditionally → RUN.
- RUN: `counter_enable_o` = !`pause_i` (combinational from state and `pause_i`; the only non-registered output term). Finished edge = `finished_i`=1 and registered previous `finished_i`=0. On edge: `periods_done_o`+1; if new value equals target → DONE, else → CLEAR.
- DONE: `done_o`=1 for exactly this cycle, `busy_o`=0; → IDLE.
- `abort_i`=1 in CLEAR, RUN or DONE → IDLE next cycle, `counter_clear_o`=1 during that IDLE entry cycle, no `done_o`, `periods_done_o` holds its value. `abort_i` in IDLE: no effect.
- Priority in one cycle: reset > abort > finished edge > pause. Finished edge while `pause_i`=1 is still counted.
- `start_i` outside IDLE is ignored; `repeat_count_i` changes after latch have no effect.
- Previous-`finished_i` register updates every cycle in all states, so a flag that is already high on entry to RUN is not counted.
- `periods_done_o` is REPEAT_WIDTH bits and never exceeds target in finite mode.

## Timing
- Reset (asserted, or any time mid-operation): state IDLE; `counter_enable_o`, `counter_clear_o`, `busy_o`, `done_o` = 0; `periods_done_o` = 0; previous-finished register = 0. Effect is immediate (asynchronous).
- Start sampled at edge N → CLEAR during cycle N..N+1 (`counter_clear_o`=1, `busy_o`=1) → RUN from edge N+1 (`counter_enable_o`=1).
- Finished edge sampled at edge M → next state CLEAR or DONE from edge M; enable low in that cycle; `periods_done_o` updated at edge M.
- Inter-period gap: exactly one cycle with enable low (CLEAR).
- `done_o` is high one cycle after the final finished edge; `busy_o` falls in the same cycle.

## Configuration
- `COUNTER_SEQUENCER_INFINITE_EN` defined: start with `repeat_count_i`=0 enters continuous mode; runs CLEAR/RUN indefinitely, `periods_done_o` wraps modulo 2^REPEAT_WIDTH, only `abort_i` or reset ends the run, `done_o` never pulses.
- Not defined: start with count 0 is ignored; state remains IDLE, all outputs unchanged.

## Test plan
- Reset with counter MAX 160, start with count 3 → `busy_o` high, three CLEAR pulses, `periods_done_o` 1,2,3, one `done_o` pulse, then IDLE with `periods_done_o`=3.
- Count 2, `pause_i` high 5 cycles mid-period → enable low exactly those 5 cycles, completion delayed by 5 cycles, `periods_done_o`=2.
- Count 5, `abort_i` after 2nd period → IDLE next cycle, one `counter_clear_o` pulse, no `done_o`, `periods_done_o`=2.
- `start_i` while busy and `finished_i` held high across CLEAR → neither is acted on; only fresh rising edges are counted.
- Count 0: without macro → no activity; with macro → run past 255 periods, `periods_done_o` wraps to 0, abort stops it.
- Assert `reset_i` in RUN → all outputs 0 immediately, new start afterward behaves as from power-up.
